// File: rtl/lc3_mem_resp.sv
// LC3 memory responder: IDLE/WAIT/DONE access FSM with wait states.
// Optional write protection below WP_LIMIT when LC3_MEM_WPROTECT_EN is defined.
module lc3_mem_resp #(
    parameter int          AW          = 8,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] WP_LIMIT    = 16'h0010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        ldMAR,
    input  logic        memWE,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        mem_ready,
    output logic        busy,
    output logic        acc_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] mar_q, mar_d;
    logic        kind_q, kind_d;
    logic [15:0] wd_q, wd_d;
    logic [15:0] rdata_q, rdata_d;
    logic        derr_q, derr_d;
    logic        berr_q, berr_d;
    logic        go;
    logic        in_rng;
    logic        wp_hit;
    logic [AW-1:0] idx;

    logic [15:0] mem [2**AW];

    // Address decode for the access about to complete
    assign idx    = mar_d[AW-1:0];
    assign in_rng = (mar_d >> AW) == 16'h0000;
`ifdef LC3_MEM_WPROTECT_EN
    assign wp_hit = kind_d & in_rng & (mar_d < WP_LIMIT);
`else
    assign wp_hit = 1'b0;
`endif

    // Next-state, access launch and completion bookkeeping
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mar_d   = mar_q;
        kind_d  = kind_q;
        wd_d    = wd_q;
        go      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ldMAR) begin
                    mar_d  = addr;
                    kind_d = memWE;
                    wd_d   = wdata;
                    cnt_d  = 3'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_DONE;
                        go      = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = S_DONE;
                    go      = 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        berr_d  = ldMAR & (state_q != S_IDLE);
        derr_d  = derr_q;
        rdata_d = rdata_q;
        if (go) begin
            derr_d = ~in_rng | wp_hit;
            if (!kind_d) begin
                rdata_d = in_rng ? mem[idx] : 16'h0000;
            end
        end
    end

    // Control and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            mar_q   <= 16'h0000;
            kind_q  <= 1'b0;
            wd_q    <= 16'h0000;
            rdata_q <= 16'h0000;
            derr_q  <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mar_q   <= mar_d;
            kind_q  <= kind_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
            derr_q  <= derr_d;
            berr_q  <= berr_d;
        end
    end

    // Storage array, deliberately not reset so contents survive rst
    always_ff @(posedge clk) begin
        if (go && kind_d && in_rng && !wp_hit) begin
            mem[idx] <= wd_d;
        end
    end

    assign rdata     = rdata_q;
    assign mem_ready = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign acc_err   = ((state_q == S_DONE) & derr_q) | berr_q;

endmodule

// File: tb/tb_lc3_mem_resp.sv
// Directed bench for lc3_mem_resp: default instance plus a zero-wait instance.
// Expected values are hand-computed constants.
module tb_lc3_mem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a_addr, a_wdata, a_rdata;
    logic        a_ld, a_we, a_ready, a_busy, a_err;
    logic [15:0] z_addr, z_wdata, z_rdata;
    logic        z_ld, z_we, z_ready, z_busy, z_err;

    int errs   = 0;
    int checks = 0;

    int          lat;
    logic [15:0] rd;
    logic        er;
    logic        seen;
    logic [15:0] old;

    always #5 clk = ~clk;

    lc3_mem_resp u0 (
        .clk(clk), .rst(rst), .addr(a_addr), .ldMAR(a_ld),
        .memWE(a_we), .wdata(a_wdata), .rdata(a_rdata),
        .mem_ready(a_ready), .busy(a_busy), .acc_err(a_err)
    );

    lc3_mem_resp #(.WAIT_CYCLES(0)) u1 (
        .clk(clk), .rst(rst), .addr(z_addr), .ldMAR(z_ld),
        .memWE(z_we), .wdata(z_wdata), .rdata(z_rdata),
        .mem_ready(z_ready), .busy(z_busy), .acc_err(z_err)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with u0 back in IDLE.
    task automatic acc(input logic [15:0] a, input logic we,
                       input logic [15:0] d, input logic tog,
                       output int l, output logic [15:0] r,
                       output logic e);
        a_addr = a; a_we = we; a_wdata = d; a_ld = 1'b1;
        @(posedge clk);
        l = 0; r = 16'hxxxx; e = 1'bx;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            a_ld = 1'b0;
            if (tog) begin
                a_addr = 16'h0030 + 16'(n); a_we = 1'b1;
                a_wdata = 16'hDEAD;
            end
            if (a_ready) begin
                l = n; r = a_rdata; e = a_err;
                break;
            end
        end
        if (l == 0) begin
            errs++;
            $display("FAIL timeout: no mem_ready within 12 cycles");
        end
        @(negedge clk);
    endtask

    task automatic zacc(input logic [15:0] a, input logic we,
                        input logic [15:0] d, output logic [15:0] r,
                        output logic e);
        z_addr = a; z_we = we; z_wdata = d; z_ld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        z_ld = 1'b0;
        chk("z_ready", 16'(z_ready), 16'h1);
        r = z_rdata; e = z_err;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        a_addr = 16'h0; a_we = 1'b0; a_wdata = 16'h0; a_ld = 1'b0;
        z_addr = 16'h0; z_we = 1'b0; z_wdata = 16'h0; z_ld = 1'b0;
        #3;
        chk("rst_busy", 16'(a_busy), 16'h0);
        chk("rst_ready", 16'(a_ready), 16'h0);
        chk("rst_err", 16'(a_err), 16'h0);
        chk("rst_rdata", a_rdata, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        // write then read back, three cycle latency each
        acc(16'h0020, 1'b1, 16'hBEEF, 1'b0, lat, rd, er);
        chk("wr_lat", 16'(lat), 16'd3);
        chk("wr_err", 16'(er), 16'h0);
        chk("wr_rdata_hold", rd, 16'h0000);
        acc(16'h0020, 1'b0, 16'h0, 1'b0, lat, rd, er);
        chk("rd_lat", 16'(lat), 16'd3);
        chk("rd_data", rd, 16'hBEEF);
        chk("rd_err", 16'(er), 16'h0);

        // input toggling during WAIT has no effect
        acc(16'h0030, 1'b1, 16'h3030, 1'b0, lat, rd, er);
        acc(16'h0031, 1'b1, 16'h3131, 1'b0, lat, rd, er);
        acc(16'h0020, 1'b0, 16'h0, 1'b1, lat, rd, er);
        chk("tog_data", rd, 16'hBEEF);
        chk("tog_lat", 16'(lat), 16'd3);
        acc(16'h0031, 1'b0, 16'h0, 1'b0, lat, rd, er);
        chk("tog_nowr31", rd, 16'h3131);
        acc(16'h0030, 1'b0, 16'h0, 1'b0, lat, rd, er);
        chk("tog_nowr30", rd, 16'h3030);

        // write to 0x0008: protected only with the macro
`ifdef LC3_MEM_WPROTECT_EN
        acc(16'h0008, 1'b0, 16'h0, 1'b0, lat, old, er);
        acc(16'h0008, 1'b1, 16'h5555, 1'b0, lat, rd, er);
        chk("wp_err", 16'(er), 16'h1);
        acc(16'h0008, 1'b0, 16'h0, 1'b0, lat, rd, er);
        chk("wp_keep", rd, old);
`else
        acc(16'h0008, 1'b1, 16'h5555, 1'b0, lat, rd, er);
        chk("wp_err", 16'(er), 16'h0);
        acc(16'h0008, 1'b0, 16'h0, 1'b0, lat, rd, er);
        chk("wp_data", rd, 16'h5555);
        acc(16'h0005, 1'b1, 16'hA5A5, 1'b0, lat, rd, er);
`endif

        // reset in the middle of a write to 0x0005
        acc(16'h0020, 1'b0, 16'h0, 1'b0, lat, rd, er);
        a_addr = 16'h0005; a_we = 1'b1; a_wdata = 16'h1111; a_ld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_ld = 1'b0;
        @(posedge clk);
        #2;
        chk("pre_rst_busy", 16'(a_busy), 16'h1);
        rst = 1'b0;
        #1;
        chk("ar_busy", 16'(a_busy), 16'h0);
        chk("ar_rdata", a_rdata, 16'h0000);
        chk("ar_err", 16'(a_err), 16'h0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen = seen | a_ready;
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen = seen | a_ready;
        end
        chk("ar_no_ready", 16'(seen), 16'h0);
        acc(16'h0005, 1'b0, 16'h0, 1'b0, lat, rd, er);
        chk("ar_lat", 16'(lat), 16'd3);
`ifndef LC3_MEM_WPROTECT_EN
        chk("ar_keep", rd, 16'hA5A5);
`endif

        // zero-wait instance: second ldMAR lands in DONE
        z_addr = 16'h0011; z_we = 1'b1; z_wdata = 16'h7777; z_ld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("z0_ready", 16'(z_ready), 16'h1);
        chk("z0_err", 16'(z_err), 16'h0);
        z_addr = 16'h0012; z_wdata = 16'h8888;
        @(posedge clk);
        @(negedge clk);
        chk("z1_ready", 16'(z_ready), 16'h0);
        chk("z1_err", 16'(z_err), 16'h1);
        chk("z1_busy", 16'(z_busy), 16'h0);
        @(posedge clk);
        @(negedge clk);
        z_ld = 1'b0;
        chk("z2_ready", 16'(z_ready), 16'h1);
        chk("z2_err", 16'(z_err), 16'h0);
        @(negedge clk);
        zacc(16'h0012, 1'b0, 16'h0, rd, er);
        chk("z_rd12", rd, 16'h8888);
        zacc(16'h0011, 1'b0, 16'h0, rd, er);
        chk("z_rd11", rd, 16'h7777);

        // out-of-range accesses
        acc(16'h0100, 1'b0, 16'h0, 1'b0, lat, rd, er);
        chk("oor_rd_data", rd, 16'h0000);
        chk("oor_rd_err", 16'(er), 16'h1);
        chk("oor_rd_lat", 16'(lat), 16'd3);
`ifndef LC3_MEM_WPROTECT_EN
        acc(16'h0000, 1'b1, 16'h0F0F, 1'b0, lat, rd, er);
`endif
        acc(16'h0020, 1'b0, 16'h0, 1'b0, lat, rd, er);
        acc(16'h0100, 1'b1, 16'h1234, 1'b0, lat, rd, er);
        chk("oor_wr_err", 16'(er), 16'h1);
        chk("oor_wr_rhold", rd, 16'hBEEF);
        acc(16'h0000, 1'b0, 16'h0, 1'b0, lat, rd, er);
        chk("oor_wr_err0", 16'(er), 16'h0);
`ifndef LC3_MEM_WPROTECT_EN
        chk("oor_no_alias", rd, 16'h0F0F);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
